vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen_if.sv | 18 +
 rtl/vga_sync_gen.sv | 88 ++++++++
 tb/tb_vga_sync_gen.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/vga_sync_gen_if.sv
// Timing outputs of the VGA sync generator, grouped for the colour stage.
// The generator drives them through master; consumers read them through slave.
interface vga_sync_gen_if;
  logic       pixel_tick;
  logic [9:0] current_row;
  logic [9:0] current_line;
  logic       enable;
  logic       hsync;
  logic       vsync;
  logic       frame_start;

  modport master (
    output pixel_tick, current_row, current_line, enable, hsync, vsync, frame_start
  );
  modport slave (
    input pixel_tick, current_row, current_line, enable, hsync, vsync, frame_start
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel-rate divider, row/line counters and registered sync,
// visible-area and frame-start strobes that all line up with the position outputs.
module vga_sync_gen #(
  parameter int unsigned DIV      = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic           clk_in,
  input  logic           rst_n,
  vga_sync_gen_if.master sync_o
);

  localparam logic [3:0] DivLast    = 4'(DIV - 1);
  localparam logic [9:0] HLast      = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VLast      = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HActive    = 10'(H_ACTIVE);
  localparam logic [9:0] VActive    = 10'(V_ACTIVE);
  localparam logic [9:0] HSyncStart = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HSyncEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VSyncStart = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VSyncEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [3:0] div_q, div_d;
  logic [9:0] row_q, row_d;
  logic [9:0] line_q, line_d;
  logic       tick_q, tick_d;
  logic       en_q, en_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       fs_q, fs_d;
  logic       row_wrap;

  always_comb begin
    div_d    = (div_q == DivLast) ? 4'd0 : div_q + 4'd1;
    tick_d   = (div_d == DivLast);
    row_wrap = tick_q && (row_q == HLast);
    row_d    = row_q;
    line_d   = line_q;
    if (tick_q) begin
      row_d = row_wrap ? 10'd0 : row_q + 10'd1;
    end
    if (row_wrap) begin
      line_d = (line_q == VLast) ? 10'd0 : line_q + 10'd1;
    end
    fs_d = row_wrap && (line_q == VLast);
    // Decode from the next position so the registered strobes match the registered counters.
    en_d = (row_d < HActive) && (line_d < VActive);
    hs_d = !((row_d >= HSyncStart) && (row_d < HSyncEnd));
    vs_d = !((line_d >= VSyncStart) && (line_d < VSyncEnd));
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= 4'd0;
      row_q  <= 10'd0;
      line_q <= 10'd0;
      tick_q <= 1'b0;
      en_q   <= 1'b0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      fs_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      row_q  <= row_d;
      line_q <= line_d;
      tick_q <= tick_d;
      en_q   <= en_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      fs_q   <= fs_d;
    end
  end

  assign sync_o.pixel_tick   = tick_q;
  assign sync_o.current_row  = row_q;
  assign sync_o.current_line = line_q;
  assign sync_o.enable       = en_q;
  assign sync_o.hsync        = hs_q;
  assign sync_o.vsync        = vs_q;
  assign sync_o.frame_start  = fs_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: a default-timing instance for tick/line behaviour and a shrunken
// instance (DIV=2, 25x8 raster) for whole-frame, frame_start and mid-sync reset behaviour.
module tb_vga_sync_gen;
  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  vga_sync_gen_if d_if ();
  vga_sync_gen_if s_if ();

  vga_sync_gen #(.DIV(4)) u_dut_d (
    .clk_in (clk),
    .rst_n  (rst_n),
    .sync_o (d_if)
  );

  vga_sync_gen #(
    .DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_dut_s (
    .clk_in (clk),
    .rst_n  (rst_n),
    .sync_o (s_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int hs_low, hs_first, hs_bad, en_hi, en_bad, d_fs, d_ticks, d_line_pre;
    int s_fs, s_first, s_last, s_int_bad, s_pos_bad, s_en, s_vs, s_en_bad, s_sync_bad;
    int guard, fs_early, fs_at_end;
    hs_low = 0; hs_first = -1; hs_bad = 0; en_hi = 0; en_bad = 0; d_fs = 0; d_ticks = 0;
    d_line_pre = -1; s_fs = 0; s_first = -1; s_last = -1; s_int_bad = 0; s_pos_bad = 0;
    s_en = 0; s_vs = 0; s_en_bad = 0; s_sync_bad = 0; fs_early = 0; fs_at_end = 0;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_d_tick", d_if.pixel_tick, 0);
    chk("rst_d_row", d_if.current_row, 0);
    chk("rst_d_line", d_if.current_line, 0);
    chk("rst_d_enable", d_if.enable, 0);
    chk("rst_d_hsync", d_if.hsync, 1);
    chk("rst_d_vsync", d_if.vsync, 1);
    chk("rst_d_fs", d_if.frame_start, 0);
    chk("rst_s_row", s_if.current_row, 0);
    chk("rst_s_enable", s_if.enable, 0);
    chk("rst_s_hsync", s_if.hsync, 1);
    chk("rst_s_vsync", s_if.vsync, 1);

    // Release on a falling edge; k counts rising edges since release.
    rst_n = 1'b1;
    @(negedge clk);  // k=1
    chk("k1_d_enable", d_if.enable, 1);
    chk("k1_d_row", d_if.current_row, 0);
    chk("k1_d_tick", d_if.pixel_tick, 0);
    chk("k1_s_tick", s_if.pixel_tick, 1);
    @(negedge clk);  // k=2
    chk("k2_d_tick", d_if.pixel_tick, 0);
    chk("k2_s_row", s_if.current_row, 1);
    chk("k2_s_tick", s_if.pixel_tick, 0);
    @(negedge clk);  // k=3
    chk("k3_d_tick", d_if.pixel_tick, 1);
    chk("k3_d_row", d_if.current_row, 0);
    @(negedge clk);  // k=4
    chk("k4_d_row", d_if.current_row, 1);
    chk("k4_d_tick", d_if.pixel_tick, 0);

    // One default line (rows 1..799 then row 0 of line 1) and eight small frames.
    for (int k = 4; k <= 3203; k++) begin
      if (k > 4) @(negedge clk);
      if (!d_if.hsync) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(d_if.current_row);
      end
      if (d_if.hsync !== !(d_if.current_row >= 656 && d_if.current_row < 752)) hs_bad++;
      if (d_if.enable) en_hi++;
      if (d_if.enable && (d_if.current_row >= 640 || d_if.current_line >= 480)) en_bad++;
      if (d_if.frame_start) d_fs++;
      if (d_if.pixel_tick) d_ticks++;
      if (k == 3199) d_line_pre = int'(d_if.current_line);
      if (s_if.frame_start) begin
        s_fs++;
        if (s_if.current_row != 0 || s_if.current_line != 0) s_pos_bad++;
        if (s_last >= 0 && k - s_last != 400) s_int_bad++;
        if (s_first < 0) s_first = k;
        s_last = k;
      end
      if (k >= 400 && k < 800) begin
        if (s_if.enable) s_en++;
        if (!s_if.vsync) s_vs++;
      end
      if (s_if.enable && (s_if.current_row >= 16 || s_if.current_line >= 4)) s_en_bad++;
      if (s_if.hsync !== !(s_if.current_row >= 18 && s_if.current_row < 22) ||
          s_if.vsync !== !(s_if.current_line >= 5 && s_if.current_line < 7)) s_sync_bad++;
    end
    chk("d_hsync_low_cycles", hs_low, 384);
    chk("d_hsync_first_row", hs_first, 656);
    chk("d_hsync_skew", hs_bad, 0);
    chk("d_enable_cycles", en_hi, 2560);
    chk("d_enable_outside", en_bad, 0);
    chk("d_tick_count", d_ticks, 800);
    chk("d_frame_start", d_fs, 0);
    chk("d_line_before_wrap", d_line_pre, 0);
    chk("d_row_after_wrap", d_if.current_row, 0);
    chk("d_line_after_wrap", d_if.current_line, 1);
    chk("s_fs_count", s_fs, 8);
    chk("s_fs_first", s_first, 400);
    chk("s_fs_interval", s_int_bad, 0);
    chk("s_fs_position", s_pos_bad, 0);
    chk("s_enable_frame", s_en, 128);
    chk("s_vsync_frame", s_vs, 100);
    chk("s_enable_outside", s_en_bad, 0);
    chk("s_sync_decode", s_sync_bad, 0);

    // Walk the small raster into its hsync pulse, then reset asynchronously mid-pulse.
    guard = 0;
    while (!(s_if.current_row == 19 && s_if.current_line == 2) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("s_reached_19_2", (s_if.current_row == 19 && s_if.current_line == 2), 1);
    chk("s_hsync_mid", s_if.hsync, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_s_row", s_if.current_row, 0);
    chk("ar_s_line", s_if.current_line, 0);
    chk("ar_s_enable", s_if.enable, 0);
    chk("ar_s_hsync", s_if.hsync, 1);
    chk("ar_s_vsync", s_if.vsync, 1);
    chk("ar_s_tick", s_if.pixel_tick, 0);
    chk("ar_s_fs", s_if.frame_start, 0);
    chk("ar_d_row", d_if.current_row, 0);
    chk("ar_d_hsync", d_if.hsync, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    d_fs = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("re_s_enable", s_if.enable, 1);
        chk("re_s_row", s_if.current_row, 0);
        chk("re_s_tick", s_if.pixel_tick, 1);
      end
      if (k == 2) chk("re_s_row_k2", s_if.current_row, 1);
      if (k == 3) chk("re_d_tick_k3", d_if.pixel_tick, 1);
      if (d_if.frame_start) d_fs++;
      if (k < 400 && s_if.frame_start) fs_early++;
      if (k == 400) fs_at_end = (s_if.frame_start && s_if.current_row == 0 &&
                                 s_if.current_line == 0) ? 1 : 0;
    end
    chk("re_s_fs_early", fs_early, 0);
    chk("re_s_fs_at_400", fs_at_end, 1);
    chk("re_d_fs", d_fs, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
